interrupt_arbiter: RTL

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

---
 rtl/nic_irq_pkg.sv | 36 +++
 rtl/irq_event_counter.sv | 21 ++
 rtl/interrupt_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nic_irq_pkg.sv
// Shared encodings and defaults for the NIC MSI interrupt arbiter.
// Also holds the round-robin pick rule shared by the arbiter logic.
package nic_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } irq_state_e;

  typedef enum logic {
    SRC_RX = 1'b0,
    SRC_TX = 1'b1
  } irq_src_e;

  localparam logic [7:0]  RX_VECTOR_DEFAULT = 8'h00;
  localparam logic [7:0]  TX_VECTOR_DEFAULT = 8'h01;
  localparam logic [31:0] TIMEOUT_DEFAULT   = 32'd65536;

  // On a tie the source that did not win last time is chosen.
  function automatic irq_src_e rr_pick(input logic rx_pend, input logic tx_pend,
                                       input irq_src_e last);
    irq_src_e pick;
    if (rx_pend && tx_pend) begin
      if (last == SRC_RX) pick = SRC_TX;
      else                pick = SRC_RX;
    end else if (rx_pend) begin
      pick = SRC_RX;
    end else begin
      pick = SRC_TX;
    end
    return pick;
  endfunction

endpackage

// File: rtl/irq_event_counter.sv
// 32-bit wrapping event counter; count updates on the clock after inc_i, never stalls.
module irq_event_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (inc_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/interrupt_arbiter.sv
// Merges Rx/Tx MSI requests onto one core port; grant one cycle after request, all outputs registered.
// Core backpressure holds the request until ack or TIMEOUT; clients wait in RELEASE until they drop.
module interrupt_arbiter
  import nic_irq_pkg::*;
#(
  parameter logic [7:0]  RX_VECTOR = RX_VECTOR_DEFAULT,
  parameter logic [7:0]  TX_VECTOR = TX_VECTOR_DEFAULT,
  parameter logic [31:0] TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_cfg_interrupt_n,
  output logic        rx_cfg_interrupt_rdy_n,
  input  logic        tx_cfg_interrupt_n,
  output logic        tx_cfg_interrupt_rdy_n,
  output logic        cfg_interrupt_n,
  input  logic        cfg_interrupt_rdy_n,
  output logic [7:0]  cfg_interrupt_di,
  output logic [31:0] rx_irq_count,
  output logic [31:0] tx_irq_count,
  output logic        irq_timeout
);

  irq_state_e  state_q, state_d;
  irq_src_e    grant_q, grant_d;
  irq_src_e    last_q, last_d;
  irq_src_e    pick;
  logic [31:0] wait_q, wait_d;
  logic        cfg_n_q, cfg_n_d;
  logic [7:0]  di_q, di_d;
  logic        rx_rdy_n_q, rx_rdy_n_d;
  logic        tx_rdy_n_q, tx_rdy_n_d;
  logic        timeout_q, timeout_d;
  logic        rx_inc, tx_inc;
  logic        any_req;
  logic        granted_req_n;
  logic        timeout_hit;

  assign any_req       = ~rx_cfg_interrupt_n | ~tx_cfg_interrupt_n;
  assign pick          = rr_pick(~rx_cfg_interrupt_n, ~tx_cfg_interrupt_n, last_q);
  assign granted_req_n = (grant_q == SRC_RX) ? rx_cfg_interrupt_n : tx_cfg_interrupt_n;
  assign timeout_hit   = (wait_q == (TIMEOUT - 32'd1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wait_d     = wait_q;
    cfg_n_d    = cfg_n_q;
    di_d       = di_q;
    rx_rdy_n_d = 1'b1;
    tx_rdy_n_d = 1'b1;
    timeout_d  = timeout_q;
    rx_inc     = 1'b0;
    tx_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          last_d  = pick;
          cfg_n_d = 1'b0;
          di_d    = (pick == SRC_RX) ? RX_VECTOR : TX_VECTOR;
          wait_d  = 32'd0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        wait_d = wait_q + 32'd1;
        // A core ack on the timeout cycle still counts as a normal completion.
        if (!cfg_interrupt_rdy_n) begin
          cfg_n_d = 1'b1;
          if (grant_q == SRC_RX) begin
            rx_rdy_n_d = 1'b0;
            rx_inc     = 1'b1;
          end else begin
            tx_rdy_n_d = 1'b0;
            tx_inc     = 1'b1;
          end
          state_d = ST_ACK;
        end else if (timeout_hit) begin
          cfg_n_d   = 1'b1;
          timeout_d = 1'b1;
          last_d    = grant_q;
          state_d   = ST_IDLE;
        end
      end

      ST_ACK: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (granted_req_n) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= SRC_RX;
      last_q     <= SRC_TX;
      wait_q     <= 32'd0;
      cfg_n_q    <= 1'b1;
      di_q       <= 8'h00;
      rx_rdy_n_q <= 1'b1;
      tx_rdy_n_q <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      cfg_n_q    <= cfg_n_d;
      di_q       <= di_d;
      rx_rdy_n_q <= rx_rdy_n_d;
      tx_rdy_n_q <= tx_rdy_n_d;
      timeout_q  <= timeout_d;
    end
  end

  irq_event_counter u_rx_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (rx_inc),
    .count_o (rx_irq_count)
  );

  irq_event_counter u_tx_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (tx_inc),
    .count_o (tx_irq_count)
  );

  assign cfg_interrupt_n        = cfg_n_q;
  assign cfg_interrupt_di       = di_q;
  assign rx_cfg_interrupt_rdy_n = rx_rdy_n_q;
  assign tx_cfg_interrupt_rdy_n = tx_rdy_n_q;
  assign irq_timeout            = timeout_q;

endmodule
